// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard inputs and stall/flush controls between pipeline and hazard_ctrl
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [4:0]       ex_rd_addr;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  // Pipeline side: presents stage status, consumes stall/flush controls
  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_opcode, ex_rd_addr, ex_redirect, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    input  ex_mem_stall, mem_wb_flush, halted, stall_cycles, flush_events
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_opcode, ex_rd_addr, ex_redirect, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    output ex_mem_stall, mem_wb_flush, halted, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the 5-stage RV32I pipeline
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_,
  hazard_ctrl_if.slave hz
);
  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;
  logic             halted_q, halted_d;

  logic memwait, loaduse, redir, rs1_hit, rs2_hit;
  logic freeze, redir_fire;

  // Raw hazard terms from the current stage contents
  always_comb begin
    memwait = hz.mem_req & ~hz.mem_ready;
    redir   = hz.ex_valid & hz.ex_redirect;
    rs1_hit = hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr);
    rs2_hit = hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr);
    loaduse = hz.id_valid & hz.ex_valid & (hz.ex_opcode == OP_LOAD) &
              (hz.ex_rd_addr != 5'd0) & (rs1_hit | rs2_hit);
  end

  // Prioritised stall/flush decode; reset forces every control low immediately
  always_comb begin
    hz.pc_stall     = 1'b0;
    hz.if_id_stall  = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_stall  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_stall = 1'b0;
    hz.mem_wb_flush = 1'b0;
    freeze          = (state_q == HALT) | memwait;
    redir_fire      = 1'b0;
    if (!rst_) begin
      if (freeze) begin
        // EX is frozen, so redirect/load-use wait until the freeze lifts
        hz.pc_stall     = 1'b1;
        hz.if_id_stall  = 1'b1;
        hz.id_ex_stall  = 1'b1;
        hz.ex_mem_stall = 1'b1;
        hz.mem_wb_flush = 1'b1;
      end else if (redir) begin
        // The dependent ID instruction is wrong-path anyway, so no load-use stall
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
        redir_fire     = 1'b1;
      end else if (loaduse) begin
        // One bubble suffices: the load reaches MEM next cycle and forwards
        hz.pc_stall    = 1'b1;
        hz.if_id_stall = 1'b1;
        hz.id_ex_flush = 1'b1;
      end
    end
  end

  // Next-state: memory-wait tracking with timeout, saturating counters
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    unique case (state_q)
      RUN: begin
        if (memwait) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (!memwait) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HALT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (hz.pc_stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (redir_fire && !(&flush_events_q)) begin
      flush_events_d = flush_events_q + CNT_W'(1);
    end
    halted_d = (state_d == HALT);
  end

  // State, counters and registered halt flag
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      halted_q       <= halted_d;
    end
  end

  assign hz.halted       = halted_q;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int CNT_W = 3;
  localparam int MEM_TIMEOUT = 4;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LUSE  = 7'b1100100;
  localparam logic [6:0] O_REDIR = 7'b0010100;
  localparam logic [6:0] O_FRZ   = 7'b1101011;

  logic clk = 1'b0;
  logic rst_;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [6:0] outs;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .hz   (hz.slave)
  );

  always #5 clk = ~clk;

  assign outs = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
                 hz.id_ex_flush, hz.ex_mem_stall, hz.mem_wb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.id_valid    = 1'b0;
    hz.id_rs1_addr = 5'd0;
    hz.id_rs2_addr = 5'd0;
    hz.id_uses_rs1 = 1'b0;
    hz.id_uses_rs2 = 1'b0;
    hz.ex_valid    = 1'b0;
    hz.ex_opcode   = 7'd0;
    hz.ex_rd_addr  = 5'd0;
    hz.ex_redirect = 1'b0;
    hz.mem_req     = 1'b0;
    hz.mem_ready   = 1'b0;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    #1;
    rst_ = 1'b0;
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    hz.ex_valid    = 1'b1;
    hz.ex_opcode   = 7'b0000011;
    hz.ex_rd_addr  = rd;
    hz.id_valid    = 1'b1;
    hz.id_rs1_addr = rd;
    hz.id_uses_rs1 = 1'b1;
  endtask

  initial begin
    rst_ = 1'b1;
    clear_in();
    #1;
    chk("rst_outs", outs, O_IDLE);
    chk("rst_halted", hz.halted, 0);
    chk("rst_stall_cnt", hz.stall_cycles, 0);
    chk("rst_flush_cnt", hz.flush_events, 0);
    hz.mem_req = 1'b1;
    #1;
    chk("rst_gates_memwait", outs, O_IDLE);
    hz.mem_req = 1'b0;
    cyc();
    rst_ = 1'b0;
    #1;

    // Load-use: exactly one bubble
    set_load_use(5'd5);
    #1;
    chk("luse_outs", outs, O_LUSE);
    cyc();
    hz.ex_valid = 1'b0;
    #1;
    chk("luse_cnt", hz.stall_cycles, 1);
    chk("luse_release", outs, O_IDLE);

    // x0 destination and unused operand never stall
    set_load_use(5'd0);
    #1;
    chk("x0_no_stall", outs, O_IDLE);
    hz.ex_rd_addr  = 5'd7;
    hz.id_rs1_addr = 5'd1;
    hz.id_rs2_addr = 5'd7;
    hz.id_uses_rs2 = 1'b0;
    #1;
    chk("rs2_unused", outs, O_IDLE);
    hz.id_uses_rs2 = 1'b1;
    #1;
    chk("rs2_used", outs, O_LUSE);
    hz.id_valid = 1'b0;
    #1;
    chk("id_invalid", outs, O_IDLE);
    clear_in();

    // Redirect overrides a coincident load-use
    set_load_use(5'd5);
    hz.ex_redirect = 1'b1;
    #1;
    chk("redir_outs", outs, O_REDIR);
    cyc();
    clear_in();
    #1;
    chk("redir_cnt", hz.flush_events, 1);
    chk("redir_no_stall_cnt", hz.stall_cycles, 1);

    // Memory wait of 3 cycles with a pending redirect
    do_reset();
    hz.mem_req     = 1'b1;
    hz.ex_valid    = 1'b1;
    hz.ex_redirect = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("memwait_outs", outs, O_FRZ);
      cyc();
    end
    hz.mem_ready = 1'b1;
    #1;
    chk("memwait_release_redir", outs, O_REDIR);
    chk("memwait_stall_cnt", hz.stall_cycles, 3);
    chk("memwait_flush_before", hz.flush_events, 0);
    cyc();
    clear_in();
    #1;
    chk("memwait_flush_after", hz.flush_events, 1);
    chk("memwait_run_outs", outs, O_IDLE);
    chk("memwait_no_halt", hz.halted, 0);

    // Timeout into HALT, then asynchronous reset
    do_reset();
    hz.mem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("to_halted_low", hz.halted, 0);
      cyc();
    end
    chk("to_halted", hz.halted, 1);
    chk("to_outs", outs, O_FRZ);
    hz.mem_req = 1'b0;
    #1;
    chk("halt_absorbing_outs", outs, O_FRZ);
    cyc();
    chk("halt_sticky", hz.halted, 1);
    chk("halt_stall_cnt", hz.stall_cycles, 5);
    hz.mem_req = 1'b1;
    #2;
    rst_ = 1'b1;
    #1;
    chk("async_rst_outs", outs, O_IDLE);
    chk("async_rst_halted", hz.halted, 0);
    chk("async_rst_cnt", hz.stall_cycles, 0);
    rst_ = 1'b0;
    clear_in();
    cyc();

    // Counter saturation at 7 with a 3-bit width
    set_load_use(5'd9);
    for (int k = 0; k < 10; k++) cyc();
    chk("sat_stall_cnt", hz.stall_cycles, 7);
    chk("sat_outs", outs, O_LUSE);
    hz.ex_redirect = 1'b1;
    for (int k = 0; k < 9; k++) cyc();
    chk("sat_flush_cnt", hz.flush_events, 7);
    chk("sat_stall_hold", hz.stall_cycles, 7);
    clear_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It drives the stall and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and freezes the pipeline while data memory is busy, with a timeout and a halt state. It also keeps saturating stall and flush counters for performance visibility.

Parameters:
MEM_TIMEOUT, 16, max consecutive memory-wait cycles before error halt (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  pipeline clock, rising edge
rst_  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a valid instruction
id_rs1_addr  input  5  ID source register 1
id_rs2_addr  input  5  ID source register 2
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_valid  input  1  EX stage holds a valid instruction
ex_opcode  input  7  EX opcode
ex_rd_addr  input  5  EX destination register
ex_redirect  input  1  EX resolved a taken branch/JAL/JALR
mem_req  input  1  MEM stage load/store is active this cycle
mem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF_ID
if_id_flush  output  1  clear IF_ID valid
id_ex_stall  output  1  hold ID_EX
id_ex_flush  output  1  clear ID_EX (insert bubble)
ex_mem_stall  output  1  hold EX_MEM
mem_wb_flush  output  1  bubble into MEM_WB
halted  output  1  error halt, sticky until reset
stall_cycles  output  CNT_W  cycles with pc_stall=1, saturating
flush_events  output  CNT_W  count of redirect flushes, saturating

Behaviour:
- State register: RUN, MEM_WAIT, HALT. Registers: state, wait_cnt (ceil(log2(MEM_TIMEOUT))+1 bits), stall_cycles, flush_events.
- Reset (rst_=1, asynchronous): state=RUN, wait_cnt=0, counters=0, halted=0. All stall/flush outputs are 0 while reset is asserted.
- Stall/flush outputs are combinational from state and current inputs, so they take effect at the same clock edge. State and counters update on the rising edge.
- Hazard terms:
  - memwait = mem_req & ~mem_ready.
  - loaduse = id_valid & ex_valid & (ex_opcode==7'b0000011) & (ex_rd_addr!=0) & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
  - redir = ex_valid & ex_redirect.
- Priority, highest first: HALT > memwait > redir > loaduse.
- HALT: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush are 1. Both flushes into IF_ID/ID_EX are 0.
- memwait (RUN or MEM_WAIT): pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush are 1. redir and loaduse are ignored because EX is frozen, and they re-evaluate when the wait releases.
- redir, no memwait: if_id_flush=1, id_ex_flush=1, no stalls. flush_events increments by 1 per cycle asserted. loaduse is suppressed.
- loaduse only: pc_stall=1, if_id_stall=1, id_ex_flush=1. This gives exactly one bubble, since the load advances to MEM the next cycle.
- Transitions:
  - RUN->MEM_WAIT on memwait, with wait_cnt=1.
  - MEM_WAIT stays while memwait; wait_cnt increments each cycle.
  - MEM_WAIT->RUN when mem_ready=1 or mem_req=0; wait_cnt clears to 0.
  - MEM_WAIT->HALT when memwait and wait_cnt==MEM_TIMEOUT-1.
  - HALT is absorbing until reset.
- On the cycle mem_ready rises, no memory stall is asserted and lower-priority hazards apply in that same cycle.
- stall_cycles increments on every cycle with pc_stall=1, including HALT. Both counters saturate at all-ones with no wrap.
- Reset asserted mid-wait or in HALT returns to RUN immediately; outputs drop without waiting for a clock edge.
- A load with rd=x0 never causes a load-use stall. id_valid=0 or ex_valid=0 also suppresses it.

Test Plan:
- Load-use: EX opcode 0000011, rd=5; ID rs1=5, uses_rs1=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. stall_cycles goes 0->1. Next cycle (EX invalid) all outputs 0.
- x0 and unused-operand filtering: load rd=0 with rs1=0 -> no stall. Load rd=7 with rs2=7 but uses_rs2=0 -> no stall.
- Redirect plus load-use in the same cycle: ex_redirect=1 with a matching load-use -> if_id_flush=1, id_ex_flush=1, pc_stall=0. flush_events=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> all four stalls and mem_wb_flush high for exactly 3 cycles. State returns to RUN, stall_cycles=3. A redirect presented during the wait fires only after release.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> halted=1 after the 4th wait cycle with all stalls held. Asserting rst_=1 mid-cycle clears halted and all outputs asynchronously.
- Saturation: CNT_W=3, hold loaduse for 10 cycles -> stall_cycles stops at 7.
